// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I/RV64I decode stage with valid/ready handshake
// Optional feature macro: DECODE_ILLEGAL_EN (registered illegal-encoding flag)
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       op,
  output logic [2:0]       fun,
  output logic [6:0]       fun7,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  logic            accept;
  logic            handshake;
  logic [2:0]      fmt_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Immediates are assembled at 32 bits, then sign-extended from instr[31] to XLEN
  always_comb begin
    fmt_d = FMT_NONE;
    imm32 = '0;
    case (in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U;
        imm32 = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_d = FMT_J;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
        fmt_d = FMT_I;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        fmt_d = FMT_S;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        fmt_d = FMT_B;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      OP_REG: fmt_d = FMT_R;
      default: ;
    endcase
  end

  assign imm_d = XLEN'($signed(imm32));

  // Flush wins over a same-cycle accept; a coincident output handshake still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      op        <= '0;
      fun       <= '0;
      fun7      <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      fmt       <= FMT_NONE;
      out_pc    <= '0;
      out_instr <= '0;
      dec_count <= '0;
    end else begin
      if (handshake) dec_count <= dec_count + CNT_W'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        op        <= in_instr[6:0];
        fun       <= in_instr[14:12];
        fun7      <= in_instr[31:25];
        rs1       <= in_instr[19:15];
        rs2       <= in_instr[24:20];
        rd        <= in_instr[11:7];
        imm       <= imm_d;
        fmt       <= fmt_d;
        out_pc    <= in_pc;
        out_instr <= in_instr;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic illegal_d;

  always_comb begin
    illegal_d = (in_instr[1:0] != 2'b11);
    case (in_instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_LOAD, OP_IMM, OP_SYSTEM,
      OP_STORE, OP_BRANCH, OP_REG, OP_FENCE: ;
      OP_JALR: if (in_instr[14:12] != 3'b000) illegal_d = 1'b1;
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (!flush && accept) begin
      illegal <= illegal_d;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
